// File: rtl/serializer_8_1bit_pkg.sv
// Shared encodings and sizes for the 8:1 one-bit serializer.
// The optional parity beat is enabled by defining SERIALIZER_PARITY_EN.
package serializer_8_1bit_pkg;
  localparam int SER_WIDTH    = 8;
  localparam int SER_SEL_BITS = 3;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  function automatic logic [SER_SEL_BITS-1:0] ser_start_idx(input bit lsb_first);
    return lsb_first ? SER_SEL_BITS'(0) : SER_SEL_BITS'(SER_WIDTH - 1);
  endfunction

  function automatic logic [SER_SEL_BITS-1:0] ser_end_idx(input bit lsb_first);
    return lsb_first ? SER_SEL_BITS'(SER_WIDTH - 1) : SER_SEL_BITS'(0);
  endfunction
endpackage

// File: rtl/serializer_8_1bit_bit_counter_3.sv
// Loadable 3-bit up/down select counter with enable and end-index flag.
module bit_counter_3 #(
  parameter bit UP = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_en,
  output logic [2:0] o_count,
  output logic       o_at_end
);
  localparam logic [2:0] START_IDX = UP ? 3'd0 : 3'd7;
  localparam logic [2:0] END_IDX   = UP ? 3'd7 : 3'd0;

  logic [2:0] r_count;
  logic       w_at_end;

  assign w_at_end = (r_count == END_IDX);

  // Stepping stops at the end index so the count can never wrap out of the byte.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= START_IDX;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !w_at_end) begin
      r_count <= UP ? (r_count + 3'd1) : (r_count - 3'd1);
    end
  end

  assign o_count  = r_count;
  assign o_at_end = w_at_end;
endmodule

// File: rtl/serializer_8_1bit_mux8.sv
// 8:1 one-bit mux cell driven by the serializer's captured byte and select.
module mux_8to1_1bit (
  input  logic [7:0] i_data,
  input  logic [2:0] i_sel,
  output logic       o_y
);
  assign o_y = i_data[i_sel];
endmodule

// File: rtl/serializer_8_1bit.sv
// Parallel-to-serial byte converter feeding an 8:1 one-bit mux, valid/ready on both sides.
// Define SERIALIZER_PARITY_EN to append an even-parity 9th beat to every byte.
module serializer_8_1bit
  import serializer_8_1bit_pkg::*;
#(
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [SER_WIDTH-1:0]    i_load_data,
  output logic                    o_ser_out,
  output logic                    o_ser_valid,
  input  logic                    i_ser_ready,
  output logic                    o_ser_last,
  output logic [SER_SEL_BITS-1:0] o_select,
  output logic                    o_busy
);
  localparam logic [SER_SEL_BITS-1:0] START_IDX = ser_start_idx(LSB_FIRST);

  ser_state_e             r_state;
  logic [SER_WIDTH-1:0]   r_data;
  logic [SER_SEL_BITS-1:0] w_select;
  logic w_at_end;
  logic w_mux_out;
  logic w_shift;
  logic w_last;
  logic w_in_parity;
  logic w_beat;
  logic w_last_done;
  logic w_accept;
  logic w_beat_bit;

  assign w_shift = (r_state == SER_SHIFT);

`ifdef SERIALIZER_PARITY_EN
  logic r_parity_phase;

  assign w_in_parity = r_parity_phase;
  assign w_last      = w_shift && r_parity_phase;

  // The parity beat follows the data beat at the end index; select holds there.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_parity_phase <= 1'b0;
    end else if (w_accept || w_last_done) begin
      r_parity_phase <= 1'b0;
    end else if (w_beat && w_at_end) begin
      r_parity_phase <= 1'b1;
    end
  end
`else
  assign w_in_parity = 1'b0;
  assign w_last      = w_shift && w_at_end;
`endif

  assign w_beat       = w_shift && i_ser_ready && !i_reset;
  assign w_last_done  = w_beat && w_last;
  assign o_load_ready = !i_reset && (!w_shift || (w_last && i_ser_ready));
  assign w_accept     = i_load_valid && o_load_ready;

  bit_counter_3 #(
    .UP (LSB_FIRST)
  ) u_bit_counter (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_accept || w_last_done),
    .i_load_val (START_IDX),
    .i_en       (w_beat && !w_in_parity),
    .o_count    (w_select),
    .o_at_end   (w_at_end)
  );

  mux_8to1_1bit u_mux (
    .i_data (r_data),
    .i_sel  (w_select),
    .o_y    (w_mux_out)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= SER_IDLE;
      r_data  <= '0;
    end else if (w_accept) begin
      r_state <= SER_SHIFT;
      r_data  <= i_load_data;
    end else if (w_last_done) begin
      r_state <= SER_IDLE;
    end
  end

  assign w_beat_bit  = w_in_parity ? (^r_data) : w_mux_out;
  assign o_ser_valid = !i_reset && w_shift;
  assign o_ser_out   = o_ser_valid ? w_beat_bit : IDLE_LEVEL;
  assign o_ser_last  = !i_reset && w_last;
  assign o_busy      = !i_reset && w_shift;
  assign o_select    = w_select;
endmodule
